// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4:1 round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ    = 4;
  localparam int SEL_W      = 2;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] exclude,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] masked;
  logic [SEL_W-1:0]   pos;

  always_comb begin
    masked = req & ~exclude;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    // Walk from the farthest position back so the nearest match wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = ptr + SEL_W'(k);
      if (masked[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with registered grant, select and data.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DW       = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [DW-1:0]        din0,
  input  logic [DW-1:0]        din1,
  input  logic [DW-1:0]        din2,
  input  logic [DW-1:0]        din3,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]     sel,
  output logic [DW-1:0]        dout,
  output logic                 dout_valid,
  output logic                 busy
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);

  state_e                  state;
  logic [SEL_W-1:0]        ptr;
  logic [HOLD_CNT_W-1:0]   hold_cnt;

  logic [DW-1:0]           din_sel;
  logic                    req_sel;
  logic                    rel;
  logic [SEL_W-1:0]        pick_ptr;
  logic [NUM_REQ-1:0]      pick_excl;
  logic [SEL_W-1:0]        pick_idx;
  logic                    pick_found;

  always_comb begin
    din_sel = din0;
    case (sel)
      2'd0:    din_sel = din0;
      2'd1:    din_sel = din1;
      2'd2:    din_sel = din2;
      default: din_sel = din3;
    endcase
  end

  assign req_sel = req[sel];
  assign rel     = !req_sel || (hold_cnt == HOLD_LIM);
  assign busy    = (state == GRANT);

  // On release the search starts after the current owner, which is skipped
  // so it only wins back the grant when nobody else is asking.
  assign pick_ptr  = (state == GRANT) ? sel + 2'd1 : ptr;
  assign pick_excl = (state == GRANT) ? onehot(sel) : '0;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .exclude (pick_excl),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt        <= '0;
      sel        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout_valid <= 1'b0;
          if (pick_found) begin
            gnt      <= onehot(pick_idx);
            sel      <= pick_idx;
            hold_cnt <= HOLD_CNT_W'(1);
            state    <= GRANT;
          end
        end
        default: begin
          dout       <= din_sel;
          dout_valid <= req_sel;
          if (rel) begin
            ptr <= sel + 2'd1;
            if (pick_found) begin
              gnt      <= onehot(pick_idx);
              sel      <= pick_idx;
              hold_cnt <= HOLD_CNT_W'(1);
            end else if (req_sel) begin
              hold_cnt <= HOLD_CNT_W'(1);
            end else begin
              gnt      <= '0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end else if (hold_cnt < HOLD_LIM) begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (HOLD_MAX 4 and 2) against an index-level model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] dina = '0, dinb = '0;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       dout_a, dout_b, dv_a, dv_b, busy_a, busy_b;
  logic [8:0] act_a, act_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DW(1), .HOLD_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .din0(dina[0]), .din1(dina[1]), .din2(dina[2]), .din3(dina[3]),
    .gnt(gnt_a), .sel(sel_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a)
  );

  mux4_rr_arbiter #(.DW(1), .HOLD_MAX(2)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .din0(dinb[0]), .din1(dinb[1]), .din2(dinb[2]), .din3(dinb[3]),
    .gnt(gnt_b), .sel(sel_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b)
  );

  assign act_a = {gnt_a, sel_a, dout_a, dv_a, busy_a};
  assign act_b = {gnt_b, sel_b, dout_b, dv_b, busy_b};

  // Reference model: owner index, hold count and pointer as plain integers.
  int   hmax [2] = '{4, 2};
  int   m_busy [2];
  int   m_sel [2];
  int   m_hold [2];
  int   m_ptr [2];
  logic m_dout [2];
  logic m_dv [2];

  function automatic int first_req(input logic [3:0] r, input int p, input int skip);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_sel[d] = 0; m_hold[d] = 0; m_ptr[d] = 0;
      m_dout[d] = 1'b0; m_dv[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d, input logic [3:0] r, input logic [3:0] dn);
    int nxt;
    if (m_busy[d] == 0) begin
      m_dv[d] = 1'b0;
      if (r != 4'b0) begin
        m_sel[d]  = first_req(r, m_ptr[d], -1);
        m_hold[d] = 1;
        m_busy[d] = 1;
      end
    end else begin
      m_dout[d] = dn[m_sel[d]];
      m_dv[d]   = r[m_sel[d]];
      if (!r[m_sel[d]] || m_hold[d] == hmax[d]) begin
        m_ptr[d] = (m_sel[d] + 1) % 4;
        nxt = first_req(r, m_ptr[d], m_sel[d]);
        if (nxt >= 0) begin
          m_sel[d]  = nxt;
          m_hold[d] = 1;
        end else if (r[m_sel[d]]) begin
          m_hold[d] = 1;
        end else begin
          m_busy[d] = 0;
        end
      end else begin
        m_hold[d] = m_hold[d] + 1;
      end
    end
  endtask

  function automatic logic [8:0] exp_vec(input int d);
    logic [3:0] g;
    g = (m_busy[d] != 0) ? (4'b0001 << m_sel[d]) : 4'b0000;
    return {g, 2'(m_sel[d]), m_dout[d], m_dv[d], (m_busy[d] != 0)};
  endfunction

  task automatic step();
    model_edge(0, req_a, dina);
    model_edge(1, req_b, dinb);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (act_a !== 9'b0 || act_b !== 9'b0) begin
      errors++;
      $display("FAIL reset_initial a=%b b=%b expected all zero", act_a, act_b);
    end
    #1 rst_n = 1'b1;
    model_reset();
    req_a = 4'b0100;
    dina  = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (act_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL reset_pregrant cyc=%0d got=%b exp=%b", c, act_a, exp_vec(0));
      end
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 4'b0 || sel_a !== 2'b0 || dv_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async gnt=%b sel=%b dv=%b busy=%b dout=%b expected zeros",
               gnt_a, sel_a, dv_a, busy_a, dout_a);
    end
    model_reset();
    #1 rst_n = 1'b1;
    req_a = 4'b1111;
    step();
    checks++;
    if (gnt_a !== 4'b0001 || sel_a !== 2'b00) begin
      errors++;
      $display("FAIL reset_ptr gnt=%b sel=%b expected 0001/00", gnt_a, sel_a);
    end
  endtask

  task automatic test_single();
    req_a = 4'b0000;
    do_reset();
    req_a = 4'b0010;
    dina  = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (gnt_a !== 4'b0010 || sel_a !== 2'b01 || act_a !== exp_vec(0) ||
          (c >= 1 && (dout_a !== 1'b1 || dv_a !== 1'b1))) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b exp=%b", c, act_a, exp_vec(0));
      end
    end
  endtask

  task automatic test_contention();
    req_a = 4'b0000;
    do_reset();
    req_a = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      dina = 4'($urandom);
      step();
      checks++;
      if (gnt_a !== (4'b0001 << ((c / 4) % 4)) || busy_a !== 1'b1 || act_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL contention cyc=%0d gnt=%b exp_gnt=%b got=%b exp=%b",
                 c, gnt_a, 4'b0001 << ((c / 4) % 4), act_a, exp_vec(0));
      end
    end
  endtask

  task automatic test_early_release();
    req_a = 4'b0000;
    do_reset();
    req_a = 4'b0011;
    dina  = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (act_a !== exp_vec(0)) begin
        errors++;
        $display("FAIL early_pre cyc=%0d got=%b exp=%b", c, act_a, exp_vec(0));
      end
    end
    req_a = 4'b0010;
    step();
    checks++;
    if (gnt_a !== 4'b0010 || sel_a !== 2'b01 || dv_a !== 1'b0 || act_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL early_release got=%b exp=%b", act_a, exp_vec(0));
    end
    step();
    checks++;
    if (dv_a !== 1'b1 || gnt_a !== 4'b0010 || act_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL early_after got=%b exp=%b", act_a, exp_vec(0));
    end
  endtask

  task automatic test_drop_expiry();
    req_a = 4'b0000;
    req_b = 4'b0000;
    do_reset();
    dinb  = 4'b1001;
    req_b = 4'b1000;
    step();
    req_b = 4'b1001;
    step();
    checks++;
    if (gnt_b !== 4'b1000 || act_b !== exp_vec(1)) begin
      errors++;
      $display("FAIL drop_expiry_pre got=%b exp=%b", act_b, exp_vec(1));
    end
    req_b = 4'b0001;
    step();
    checks++;
    if (gnt_b !== 4'b0001 || sel_b !== 2'b00 || act_b !== exp_vec(1)) begin
      errors++;
      $display("FAIL drop_expiry gnt=%b sel=%b expected 0001/00", gnt_b, sel_b);
    end
    step();
    step();
    checks++;
    if (gnt_b !== 4'b0001 || act_b !== exp_vec(1)) begin
      errors++;
      $display("FAIL drop_expiry_sole got=%b exp=%b", act_b, exp_vec(1));
    end
    req_b = 4'b0000;
  endtask

  task automatic test_idle_return();
    req_a = 4'b0000;
    do_reset();
    req_a = 4'b0100;
    dina  = 4'b0100;
    step();
    step();
    req_a = 4'b0000;
    step();
    checks++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b0 || sel_a !== 2'b10 || dv_a !== 1'b0 ||
        dout_a !== 1'b1 || act_a !== exp_vec(0)) begin
      errors++;
      $display("FAIL idle_return got=%b exp=%b", act_a, exp_vec(0));
    end
    dina = 4'b0000;
    step();
    checks++;
    if (sel_a !== 2'b10 || dout_a !== 1'b1 || dv_a !== 1'b0 || gnt_a !== 4'b0000) begin
      errors++;
      $display("FAIL idle_hold sel=%b dout=%b dv=%b gnt=%b", sel_a, dout_a, dv_a, gnt_a);
    end
  endtask

  task automatic test_random();
    req_a = 4'b0000;
    req_b = 4'b0000;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 4'($urandom);
      dina = 4'($urandom);
      dinb = 4'($urandom);
      step();
      checks++;
      if (act_a !== exp_vec(0) || act_b !== exp_vec(1)) begin
        errors++;
        $display("FAIL random cyc=%0d a=%b exp_a=%b b=%b exp_b=%b",
                 c, act_a, exp_vec(0), act_b, exp_vec(1));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_drop_expiry();
    test_idle_return();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
